// File: rtl/regf_wbq.sv
// -----------------------------------------------------------------------------
// regf_wbq - writeback queue in front of a single-write-port register file.
//
// Two producers (port 0 = ALU, port 1 = load unit) may each deliver one result
// per cycle. Results are buffered in arrival order in a circular buffer and
// drained one per cycle into the register-file write port. A three-port
// bypass lookup exposes values that are queued but not yet written.
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_valid0/i_waddr0/i_wdata0   port 0 (ALU) result
//   i_valid1/i_waddr1/i_wdata1   port 1 (load) result, younger than port 0
//   o_ready                      room for two pushes this cycle
//   i_hold                       suppress drain this cycle
//   o_we/o_waddr/o_wdata         register-file write port (head entry)
//   i_raddrK / o_hitK / o_hdataK bypass lookup, K = 0..2
//   o_count                      occupied entries
// -----------------------------------------------------------------------------
module regf_wbq #(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid0,
  input  logic [5:0]                 i_waddr0,
  input  logic [31:0]                i_wdata0,
  input  logic                       i_valid1,
  input  logic [5:0]                 i_waddr1,
  input  logic [31:0]                i_wdata1,
  output logic                       o_ready,
  input  logic                       i_hold,
  output logic                       o_we,
  output logic [5:0]                 o_waddr,
  output logic [31:0]                o_wdata,
  input  logic [5:0]                 i_raddr0,
  input  logic [5:0]                 i_raddr1,
  input  logic [5:0]                 i_raddr2,
  output logic                       o_hit0,
  output logic                       o_hit1,
  output logic                       o_hit2,
  output logic [31:0]                o_hdata0,
  output logic [31:0]                o_hdata1,
  output logic [31:0]                o_hdata2,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [5:0]    r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_ok0;
  logic          w_ok1;
  logic          w_pop;
  logic          w_nempty;
  logic [PW-1:0] w_tail1;
  logic [CW-1:0] w_npush;

  // $zero and $pc are architecturally not written through this path.
  function automatic logic f_keep(input logic [5:0] a);
    return (a != 6'd0) && (a != 6'd63);
  endfunction

  // Oldest-to-youngest scan over occupied slots; a later match overwrites an
  // earlier one so the youngest value wins.
  function automatic logic [32:0] f_bypass(input logic [5:0] a);
    logic [32:0]   res;
    logic [PW-1:0] idx;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = r_head + PW'(i);
      if ((CW'(i) < r_count) && (r_addr[idx] == a) && f_keep(a))
        res = {1'b1, r_data[idx]};
    end
    return res;
  endfunction

  // Readiness looks only at the registered count, so a same-cycle pop never
  // opens room for a push; pushes are granted in pairs.
  assign o_ready  = (r_count <= CW'(DEPTH - 2));
  assign w_nempty = (r_count != '0);
  assign w_pop    = w_nempty && !i_hold;
  assign o_we     = w_pop;
  assign o_count  = r_count;

  assign w_ok0   = i_valid0 && o_ready && f_keep(i_waddr0);
  assign w_ok1   = i_valid1 && o_ready && f_keep(i_waddr1);
  // Port 1 lands behind port 0 when both are enqueued together.
  assign w_tail1 = w_ok0 ? (r_tail + PW'(1)) : r_tail;
  assign w_npush = {{(CW-1){1'b0}}, w_ok0} + {{(CW-1){1'b0}}, w_ok1};

  // Gate the head so stale storage never shows on the write port when empty.
  assign o_waddr = w_nempty ? r_addr[r_head] : 6'd0;
  assign o_wdata = w_nempty ? r_data[r_head] : 32'd0;

  always_comb begin
    {o_hit0, o_hdata0} = f_bypass(i_raddr0);
    {o_hit1, o_hdata1} = f_bypass(i_raddr1);
    {o_hit2, o_hdata2} = f_bypass(i_raddr2);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + {{(PW-1){1'b0}}, w_pop};
      r_tail  <= r_tail + w_npush[PW-1:0];
      r_count <= r_count + w_npush - {{(CW-1){1'b0}}, w_pop};
    end
  end

  // Slot contents are only meaningful while counted, so they need no reset.
  always_ff @(posedge i_clk) begin
    if (w_ok0) begin
      r_addr[r_tail] <= i_waddr0;
      r_data[r_tail] <= i_wdata0;
    end
    if (w_ok1) begin
      r_addr[w_tail1] <= i_waddr1;
      r_data[w_tail1] <= i_wdata1;
    end
  end

endmodule

// File: doc/regf_wbq.md
# regf_wbq

Writeback queue between the execution units and the register file. Two producers (ALU, load unit) can each deliver a result per cycle, but the register file has one write port. This block buffers results in order and drains one per cycle into that port. It also exposes a bypass lookup so the operand-read stage sees values that are queued but not yet written.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, ≥ 2.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid0  in  1  port 0 (ALU) result valid.
- i_waddr0  in  6  port 0 destination register.
- i_wdata0  in  32  port 0 result.
- i_valid1  in  1  port 1 (load) result valid.
- i_waddr1  in  6  port 1 destination register.
- i_wdata1  in  32  port 1 result.
- o_ready  out  1  both ports may push this cycle.
- i_hold  in  1  suppress drain this cycle (write port borrowed).
- o_we  out  1  register-file write enable.
- o_waddr  out  6  register-file write address.
- o_wdata  out  32  register-file write data.
- i_raddr0, i_raddr1, i_raddr2  in  6 each  bypass lookup addresses.
- o_hit0, o_hit1, o_hit2  out  1 each  a pending entry matches.
- o_hdata0, o_hdata1, o_hdata2  out  32 each  youngest matching pending value.
- o_count  out  clog2(DEPTH)+1  occupied entries.

## Operation
- Storage is a circular buffer with head and tail pointers of clog2(DEPTH) bits that wrap modulo DEPTH. Each entry holds {addr[5:0], data[31:0]}.
- Push acceptance is `i_validK && o_ready`.
- Results addressed to register 0 ($zero) or register 63 ($pc) are accepted and discarded. They are never queued.
- When both ports push in the same cycle, port 0 is enqueued first (older) and port 1 second (younger).
- `o_ready` = (DEPTH − o_count) ≥ 2. It is computed from the registered count only, not from the same-cycle pop.
- Drain:
  - `o_we` = (o_count ≠ 0) && !i_hold.
  - `o_waddr`/`o_wdata` = head entry (combinational).
  - Head advances on the edge where `o_we` = 1.
- Count update per edge: count + pushes_enqueued − pop. Push and pop in the same cycle are legal, and so are two pushes plus a pop.
- Bypass, per read port K:
  - Search all occupied entries, including the head being drained this cycle.
  - `o_hitK` = any entry addr == i_raddrK.
  - `o_hdataK` = data of the youngest matching entry.
  - With no hit, `o_hdataK` = 0.
  - Addresses 0 and 63 never hit.
- Same-cycle pushes are not visible to bypass until the next cycle.
- Pushes while `o_ready` = 0 are a protocol error and are ignored: no enqueue, no state change.

## Timing
- Reset (async, immediate):
  - head = tail = count = 0.
  - `o_we` = 0, `o_ready` = 1, all `o_hitK` = 0, all `o_hdataK` = 0, `o_waddr` = 0, `o_wdata` = 0.
  - Reset mid-drain discards all entries and asserts no write.
- Push on edge N:
  - Entry visible to bypass and `o_count` in cycle N+1.
  - If it is at the head, `o_we` = 1 in cycle N+1.
  - Register file is updated at edge N+1 (earliest).
- Drain throughput: one entry per cycle while `i_hold` = 0.
- Full: count = DEPTH → `o_ready` = 0. Count = DEPTH−1 → `o_ready` = 0 as well, because pushes are granted in pairs.
- Empty: `o_we` = 0 regardless of `i_hold`; no bypass hits.
- Pointer wrap: tail at DEPTH−1 with a double push writes entries DEPTH−1 and 0.

## Test plan
- Reset values: assert i_rst mid-stream with 3 entries queued → `o_count` = 0, `o_we` = 0, `o_ready` = 1 immediately; after release, no writes appear.
- Ordering: same cycle, port0 pushes (r5, 0x11) and port1 pushes (r5, 0x22) → o_waddr/o_wdata sequence (5, 0x11) then (5, 0x22); i_raddr0 = 5 before the drain → hit with 0x22.
- Discard: push (r0, 0xAA) and (r63, 0xBB) → `o_count` stays 0, `o_we` never asserted, `o_ready` stays 1.
- Backpressure, DEPTH = 4: hold `i_hold` = 1 and double-push twice → `o_count` = 4, `o_ready` = 0. A third push is ignored. Release hold → 4 writes on consecutive cycles, in order.
- Wrap: run 20 alternating single and double pushes, with `i_hold` randomly 0/1 → write sequence matches a reference FIFO model and `o_count` never exceeds 4.
- Bypass on head: queue (r7, 0x1234) and drain it with `i_raddr2` = 7 in the drain cycle → `o_hit2` = 1 and `o_hdata2` = 0x1234 that cycle; `o_hit2` = 0 the next cycle.
